fetch_unit: RTL and testbench

//  Instruction fetch stage: the producer end of the instruction interface that decode consumes.

---
 rtl/wisc_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_pc_reg.sv | 43 ++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// wisc_pkg: opcodes, NOP word, fetch state encoding and PC width shared by the fetch stage. rev 1.0
`default_nettype none

package wisc_pkg;

    localparam int          PC_W     = 16;
    localparam logic [4:0]  OP_HALT  = 5'b00000;
    localparam logic [4:0]  OP_NOP   = 5'b00001;
    localparam logic [15:0] NOP_WORD = 16'h0800;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, redirect and decode handshake bundle of the fetch stage. rev 1.0
`default_nettype none

interface fetch_unit_if #(
    parameter int PC_W = wisc_pkg::PC_W
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rdy;
    logic [15:0]     imem_data;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [15:0]     instruction;
    logic [PC_W-1:0] pc_plus2;
    logic            halted;
    logic            err;

    modport master (
        output imem_req, imem_addr, inst_valid, instruction, pc_plus2, halted, err,
        input  imem_rdy, imem_data, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, instruction, pc_plus2, halted, err,
        output imem_rdy, imem_data, redirect, redirect_pc, inst_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with +2 incrementer (modulo 2^PC_W) and redirect load mux. rev 1.0
`default_nettype none

module fetch_pc_reg #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            advance,
    input  wire logic            load,
    input  wire logic [PC_W-1:0] load_pc,
    output logic      [PC_W-1:0] pc,
    output logic      [PC_W-1:0] pc_plus2
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    assign pc_plus2 = pc_q + PC_W'(2);
    assign pc       = pc_q;

    // A redirect wins over a same-cycle advance.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (advance) begin
            pc_d = pc_plus2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage FSM, one-word instruction buffer and decode handshake.
// FETCH_ALIGN_ERR_EN: odd redirect target raises sticky err and halts; otherwise bit 0 is cleared. rev 1.0
`default_nettype none

module fetch_unit #(
    parameter int              PC_W     = wisc_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fetch_unit_if.master     bus
);

    import wisc_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_plus2_q, pc_plus2_d;
    logic            err_q, err_d;

    logic            take_redirect;
    logic            align_err;
    logic [PC_W-1:0] target_pc;
    logic            fetch_done;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;

    assign take_redirect = bus.redirect && (state_q != ST_HALTED);

`ifdef FETCH_ALIGN_ERR_EN
    assign align_err = take_redirect && bus.redirect_pc[0];
    assign target_pc = bus.redirect_pc;
`else
    assign align_err = 1'b0;
    assign target_pc = bus.redirect_pc & ~PC_W'(1);
`endif

    // Data arriving alongside a redirect belongs to the abandoned path and is dropped.
    assign fetch_done = (state_q == ST_FETCH) && bus.imem_rdy && !take_redirect;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .advance  (fetch_done),
        .load     (take_redirect && !align_err),
        .load_pc  (target_pc),
        .pc       (pc),
        .pc_plus2 (pc_inc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (bus.imem_rdy) state_d = ST_HOLD;
            ST_HOLD:   if (bus.inst_ready) state_d = (instr_q[15:11] == OP_HALT) ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
        // Redirect squashes any same-cycle fetch completion or HALT acceptance.
        if (take_redirect) begin
            state_d = align_err ? ST_HALTED : ST_FETCH;
        end
    end

    always_comb begin
        bus.imem_req   = (state_q == ST_FETCH);
        bus.inst_valid = (state_q == ST_HOLD);
        bus.halted     = (state_q == ST_HALTED);
    end

    always_comb begin
        instr_d    = instr_q;
        pc_plus2_d = pc_plus2_q;
        err_d      = err_q | align_err;
        if (fetch_done) begin
            instr_d    = bus.imem_data;
            pc_plus2_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q    <= NOP_WORD;
            pc_plus2_q <= '0;
            err_q      <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
            err_q      <= err_d;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.instruction = instr_q;
    assign bus.pc_plus2    = pc_plus2_q;
    assign bus.err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit reset, handshake, stalls, redirects, HALT and PC wrap. rev 1.0
`default_nettype none

module tb_fetch_unit;

    logic clk;
    logic rst;
    logic halt_word;
    int   n_checks;
    int   n_errors;

    fetch_unit_if #(.PC_W(16)) bus ();

    fetch_unit #(
        .PC_W     (16),
        .RESET_PC (16'h0000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns opcode 00010 with the low address bits, or a HALT word when selected.
    always_comb begin
        bus.imem_data = halt_word ? 16'h0000 : {5'b00010, bus.imem_addr[10:0]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        halt_word       = 1'b0;
        rst             = 1'b0;
        bus.imem_rdy    = 1'b0;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        tick();
        tick();
        check("rst_req",   bus.imem_req,    1);
        check("rst_addr",  bus.imem_addr,   16'h0000);
        check("rst_valid", bus.inst_valid,  0);
        check("rst_instr", bus.instruction, 16'h0800);
        check("rst_pcp2",  bus.pc_plus2,    16'h0000);
        check("rst_halt",  bus.halted,      0);
        check("rst_err",   bus.err,         0);
        rst = 1'b1;

        // Back-to-back fetches at 0 and 2.
        bus.imem_rdy   = 1'b1;
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("t1_req",  bus.imem_req,  1);
            check("t1_addr", bus.imem_addr, 32'(2 * k));
            tick();
            check("t1_valid", bus.inst_valid,  1);
            check("t1_instr", bus.instruction, 32'h1000 + 32'(2 * k));
            check("t1_pcp2",  bus.pc_plus2,    32'(2 * k + 2));
            check("t1_noreq", bus.imem_req,    0);
            tick();
        end

        // Slow memory at 0x0004.
        bus.imem_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t2_addr",  bus.imem_addr,  16'h0004);
            check("t2_req",   bus.imem_req,   1);
            check("t2_valid", bus.inst_valid, 0);
            tick();
        end
        check("t2_wait", bus.inst_valid, 0);
        bus.imem_rdy = 1'b1;
        tick();
        check("t2_valid1", bus.inst_valid,  1);
        check("t2_instr",  bus.instruction, 16'h1004);
        check("t2_pcp2",   bus.pc_plus2,    16'h0006);

        // Decode stall while holding.
        bus.imem_rdy   = 1'b0;
        bus.inst_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_valid", bus.inst_valid,  1);
            check("t3_instr", bus.instruction, 16'h1004);
            check("t3_pcp2",  bus.pc_plus2,    16'h0006);
            check("t3_req",   bus.imem_req,    0);
        end
        bus.inst_ready = 1'b1;
        bus.imem_rdy   = 1'b1;
        tick();
        check("t3_addr", bus.imem_addr,  16'h0006);
        check("t3_drop", bus.inst_valid, 0);

        // Redirect coincident with imem_rdy.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        tick();
        check("t4_addr",  bus.imem_addr,  16'h0100);
        check("t4_valid", bus.inst_valid, 0);
        check("t4_req",   bus.imem_req,   1);
        bus.redirect = 1'b0;
        tick();
        check("t4_instr", bus.instruction, 16'h1100);
        check("t4_pcp2",  bus.pc_plus2,    16'h0102);

        // HALT squashed by redirect, then HALT accepted.
        halt_word = 1'b1;
        tick();
        check("t5_addr", bus.imem_addr, 16'h0102);
        tick();
        check("t5_hword", bus.instruction, 16'h0000);
        check("t5_hval",  bus.inst_valid,  1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0200;
        tick();
        check("t5_squash", bus.halted,    0);
        check("t5_raddr",  bus.imem_addr, 16'h0200);
        bus.redirect = 1'b0;
        tick();
        check("t5_pcp2", bus.pc_plus2, 16'h0202);
        tick();
        check("t5_halted", bus.halted,     1);
        check("t5_hreq",   bus.imem_req,   0);
        check("t5_hvalid", bus.inst_valid, 0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0300;
        tick();
        check("t5_ignore", bus.halted,   1);
        check("t5_noreq",  bus.imem_req, 0);
        bus.redirect = 1'b0;
        halt_word    = 1'b0;
        bus.imem_rdy = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_raddr0", bus.imem_addr, 16'h0000);
        check("t5_rreq",   bus.imem_req,  1);
        check("t5_rhalt",  bus.halted,    0);
        #3;
        rst = 1'b1;
        tick();

        // PC wrap at 0xFFFE.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        tick();
        check("t6_addr", bus.imem_addr, 16'hFFFE);
        bus.redirect = 1'b0;
        bus.imem_rdy = 1'b1;
        tick();
        check("t6_instr", bus.instruction, 16'h17FE);
        check("t6_pcp2",  bus.pc_plus2,    16'h0000);
        bus.imem_rdy   = 1'b0;
        bus.inst_ready = 1'b1;
        tick();
        check("t6_wrap", bus.imem_addr, 16'h0000);

        // Odd redirect target.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0101;
        tick();
`ifdef FETCH_ALIGN_ERR_EN
        check("t6_err",   bus.err,      1);
        check("t6_halt",  bus.halted,   1);
        check("t6_noreq", bus.imem_req, 0);
`else
        check("t6_align", bus.imem_addr, 16'h0100);
        check("t6_noerr", bus.err,       0);
        check("t6_run",   bus.halted,    0);
`endif
        bus.redirect = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
